upper_pipe: RTL and testbench

//  Registered, parametrised upper-immediate unit for LUI/AUIPC writeback in the execute stage.

---
 rtl/upper_pipe_if.sv | 34 +++
 rtl/upper_pipe.sv | 113 +++++++++++
 tb/tb_upper_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/upper_pipe_if.sv
// Handshake bundle for the upper-immediate unit.
//  Issue channel  : in_valid/in_ready with in_pc, in_imm, in_opcode, in_rd.
//  Result channel : out_valid/out_ready with out_result, out_rd, out_illegal.
//  master : the side that issues ops and consumes results (pipeline / testbench).
//  slave  : the upper_pipe unit itself.
interface upper_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [19:0]      in_imm;
  logic [6:0]       in_opcode;
  logic [TAG_W-1:0] in_rd;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport master (
    output in_valid, in_pc, in_imm, in_opcode, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_opcode, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );

endinterface

// File: rtl/upper_pipe.sv
// Registered LUI/AUIPC result unit for the execute stage.
// Ops arrive over a valid/ready handshake, the result is computed combinationally
// at the input and written into a DEPTH-entry FIFO; results leave from the FIFO
// head in acceptance order. Unsupported opcodes produce a zero result with the
// illegal flag set so the exception can be raised downstream.
// Ports:
//  clk   - rising-edge clock
//  rst_n - synchronous active-low reset
//  flush - drops all buffered ops and any op presented this cycle
//  io    - upper_pipe_if.slave handshake bundle (issue and result channels)
module upper_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  upper_pipe_if.slave   io
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [XLEN-1:0]  res_mem [DEPTH];
  logic [TAG_W-1:0] rd_mem  [DEPTH];
  logic [DEPTH-1:0] ill_mem;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  u_imm;
  logic [XLEN-1:0]  res_d;
  logic             ill_d;

  // The U immediate is sign-extended from bit 31 on RV64 only.
  if (XLEN == 64) begin : g_u64
    assign u_imm = {{32{io.in_imm[19]}}, io.in_imm, 12'b0};
  end else begin : g_u32
    assign u_imm = {io.in_imm, 12'b0};
  end

  // in_ready only looks at FIFO occupancy and reset, never at out_ready, so
  // writeback backpressure has no combinational path back to issue.
  assign full          = (count == CNT_W'(DEPTH));
  assign io.in_ready   = !full && rst_n;
  assign push          = io.in_valid && io.in_ready;
  assign io.out_valid  = (count != '0);
  assign pop           = io.out_valid && io.out_ready;

  always_comb begin
    res_d = '0;
    ill_d = 1'b1;
    case (io.in_opcode)
      OP_LUI: begin
        res_d = u_imm;
        ill_d = 1'b0;
      end
      OP_AUIPC: begin
        res_d = io.in_pc + u_imm;
        ill_d = 1'b0;
      end
      default: begin
        res_d = '0;
        ill_d = 1'b1;
      end
    endcase
  end

  // Occupancy and pointers. Flush and reset clear everything and discard any
  // push or pop in the same cycle; reset wins because it is tested first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wptr] <= res_d;
      rd_mem[wptr]  <= io.in_rd;
      ill_mem[wptr] <= ill_d;
    end
  end

  // Head fields read as zero whenever the FIFO is empty (after reset or flush).
  assign io.out_result  = io.out_valid ? res_mem[rptr] : '0;
  assign io.out_rd      = io.out_valid ? rd_mem[rptr]  : '0;
  assign io.out_illegal = io.out_valid ? ill_mem[rptr] : 1'b0;

endmodule

// File: tb/tb_upper_pipe.sv
// Directed bench for upper_pipe: one RV64 and one RV32 instance sharing clock,
// reset and flush. A vector table covers the per-op results; hand-written
// sequences cover backpressure, throughput, flush and mid-stream reset.
module tb_upper_pipe;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic clk;
  logic rst_n;
  logic flush;

  int checks;
  int errors;

  upper_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();
  upper_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();

  upper_pipe #(.XLEN(64), .TAG_W(5), .DEPTH(2)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (if64.slave)
  );

  upper_pipe #(.XLEN(32), .TAG_W(5), .DEPTH(2)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (if32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is64;
    logic [63:0] pc;
    logic [19:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [63:0] exp_res;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [10];

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive64(input logic valid, input logic [63:0] pc, input logic [19:0] imm,
                         input logic [6:0] op, input logic [4:0] rd);
    if64.in_valid  = valid;
    if64.in_pc     = pc;
    if64.in_imm    = imm;
    if64.in_opcode = op;
    if64.in_rd     = rd;
  endtask

  task automatic drive32(input logic valid, input logic [31:0] pc, input logic [19:0] imm,
                         input logic [6:0] op, input logic [4:0] rd);
    if32.in_valid  = valid;
    if32.in_pc     = pc;
    if32.in_imm    = imm;
    if32.in_opcode = op;
    if32.in_rd     = rd;
  endtask

  // Present one op with out_ready high, accept it, check the head, then pop it.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is64) drive64(1'b1, v.pc, v.imm, v.op, v.rd);
    else        drive32(1'b1, v.pc[31:0], v.imm, v.op, v.rd);
    tick();
    if64.in_valid = 1'b0;
    if32.in_valid = 1'b0;
    if (v.is64) begin
      checkOutput({tag, "_valid"},   64'(if64.out_valid),   64'd1);
      checkOutput({tag, "_result"},  if64.out_result,       v.exp_res);
      checkOutput({tag, "_rd"},      64'(if64.out_rd),      64'(v.rd));
      checkOutput({tag, "_illegal"}, 64'(if64.out_illegal), 64'(v.exp_ill));
    end else begin
      checkOutput({tag, "_valid"},   64'(if32.out_valid),   64'd1);
      checkOutput({tag, "_result"},  64'(if32.out_result),  v.exp_res);
      checkOutput({tag, "_rd"},      64'(if32.out_rd),      64'(v.rd));
      checkOutput({tag, "_illegal"}, 64'(if32.out_illegal), 64'(v.exp_ill));
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, 64'h0,                  20'h80000, LUI,     5'd3,  64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[1] = '{1'b1, 64'h1000,               20'h00001, AUIPC,   5'd4,  64'h0000_0000_0000_2000, 1'b0};
    vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_F000, 20'h00001, AUIPC,  5'd5,  64'h0,                   1'b0};
    vecs[3] = '{1'b1, 64'h55,                 20'h12345, 7'h33,   5'd7,  64'h0,                   1'b1};
    vecs[4] = '{1'b1, 64'h0,                  20'h7FFFF, LUI,     5'd31, 64'h0000_0000_7FFF_F000, 1'b0};
    vecs[5] = '{1'b1, 64'h10,                 20'hFFFFF, AUIPC,   5'd1,  64'hFFFF_FFFF_FFFF_F010, 1'b0};
    vecs[6] = '{1'b0, 64'h0,                  20'h80000, LUI,     5'd3,  64'h0000_0000_8000_0000, 1'b0};
    vecs[7] = '{1'b0, 64'hFFFF_F000,          20'h00001, AUIPC,   5'd6,  64'h0,                   1'b0};
    vecs[8] = '{1'b0, 64'h0000_0104,          20'h12345, AUIPC,   5'd9,  64'h0000_0000_1234_5104, 1'b0};
    vecs[9] = '{1'b0, 64'h0,                  20'hABCDE, 7'h13,   5'd2,  64'h0,                   1'b1};

    rst_n = 1'b0;
    flush = 1'b0;
    drive64(1'b0, 64'h0, 20'h0, 7'h0, 5'd0);
    drive32(1'b0, 32'h0, 20'h0, 7'h0, 5'd0);
    if64.out_ready = 1'b1;
    if32.out_ready = 1'b1;

    // Reset state
    tick();
    #1;
    checkOutput("rst_in_ready_low", 64'(if64.in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid",   64'(if64.out_valid),   64'd0);
    checkOutput("rst_out_result",  if64.out_result,       64'd0);
    checkOutput("rst_out_rd",      64'(if64.out_rd),      64'd0);
    checkOutput("rst_out_illegal", 64'(if64.out_illegal), 64'd0);
    checkOutput("rst_in_ready",    64'(if64.in_ready),    64'd1);
    checkOutput("rst32_out_valid", 64'(if32.out_valid),   64'd0);
    checkOutput("rst32_in_ready",  64'(if32.in_ready),    64'd1);

    // Table-driven single ops
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Backpressure: third op held until the consumer drains
    if64.out_ready = 1'b0;
    drive64(1'b1, 64'h0, 20'h00001, LUI, 5'd1);
    checkOutput("bp_ready0", 64'(if64.in_ready), 64'd1);
    tick();
    drive64(1'b1, 64'h0, 20'h00002, LUI, 5'd2);
    checkOutput("bp_ready1", 64'(if64.in_ready), 64'd1);
    tick();
    drive64(1'b1, 64'h0, 20'h00003, LUI, 5'd3);
    checkOutput("bp_ready_full", 64'(if64.in_ready), 64'd0);
    tick();
    checkOutput("bp_held_ready",  64'(if64.in_ready), 64'd0);
    checkOutput("bp_held_result", if64.out_result,    64'h1000);
    checkOutput("bp_held_rd",     64'(if64.out_rd),   64'd1);
    if64.out_ready = 1'b1;
    tick();
    checkOutput("bp_drain1_result", if64.out_result,    64'h2000);
    checkOutput("bp_drain1_rd",     64'(if64.out_rd),   64'd2);
    checkOutput("bp_drain1_ready",  64'(if64.in_ready), 64'd1);
    tick();
    if64.in_valid = 1'b0;
    checkOutput("bp_drain2_result", if64.out_result,     64'h3000);
    checkOutput("bp_drain2_rd",     64'(if64.out_rd),    64'd3);
    tick();
    checkOutput("bp_empty", 64'(if64.out_valid), 64'd0);

    // Back-to-back ops with out_ready high: one result per clock
    for (int i = 0; i < 4; i++) begin
      logic [63:0] exp;
      if (i % 2 == 0) begin
        drive64(1'b1, 64'h100, 20'(i + 1), LUI, 5'(i + 10));
        exp = 64'(i + 1) << 12;
      end else begin
        drive64(1'b1, 64'h100, 20'(i + 1), AUIPC, 5'(i + 10));
        exp = 64'h100 + (64'(i + 1) << 12);
      end
      tick();
      checkOutput($sformatf("b2b%0d_valid", i),  64'(if64.out_valid), 64'd1);
      checkOutput($sformatf("b2b%0d_result", i), if64.out_result,     exp);
      checkOutput($sformatf("b2b%0d_ready", i),  64'(if64.in_ready),  64'd1);
    end
    if64.in_valid = 1'b0;
    tick();
    checkOutput("b2b_done", 64'(if64.out_valid), 64'd0);

    // Flush with two entries buffered and an op presented
    if64.out_ready = 1'b0;
    drive64(1'b1, 64'h0, 20'h00011, LUI, 5'd11);
    tick();
    drive64(1'b1, 64'h0, 20'h00012, LUI, 5'd12);
    tick();
    drive64(1'b1, 64'h0, 20'h00013, LUI, 5'd13);
    flush = 1'b1;
    if64.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    if64.in_valid = 1'b0;
    checkOutput("flush_valid",  64'(if64.out_valid), 64'd0);
    checkOutput("flush_result", if64.out_result,     64'd0);
    tick();
    checkOutput("flush_still_empty", 64'(if64.out_valid), 64'd0);

    // Flush at count 1 discards the concurrent push as well
    drive64(1'b1, 64'h0, 20'h00021, LUI, 5'd21);
    if64.out_ready = 1'b0;
    tick();
    drive64(1'b1, 64'h0, 20'h00022, LUI, 5'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if64.in_valid = 1'b0;
    checkOutput("flush_push_dropped", 64'(if64.out_valid), 64'd0);

    // Reset mid-stream with two entries buffered
    drive64(1'b1, 64'h0, 20'h00031, LUI, 5'd1);
    tick();
    drive64(1'b1, 64'h0, 20'h00032, LUI, 5'd2);
    tick();
    drive64(1'b1, 64'h0, 20'h00033, LUI, 5'd3);
    rst_n = 1'b0;
    if64.out_ready = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", 64'(if64.in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    if64.in_valid = 1'b0;
    #1;
    checkOutput("rst_mid_valid",    64'(if64.out_valid), 64'd0);
    checkOutput("rst_mid_result",   if64.out_result,     64'd0);
    checkOutput("rst_mid_in_ready2", 64'(if64.in_ready), 64'd1);
    tick();
    checkOutput("rst_mid_still_empty", 64'(if64.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
